// File: rtl/ft_cmd_ctrl.sv
// ft_cmd_ctrl: RX command assembler/decoder, LED register and single-owner TX sequencer; FT_CMD_TIMEOUT_EN adds a partial-command timeout
module ft_cmd_ctrl #(
    parameter int         LED_W       = 8,
    parameter int         CNT_W       = 24,
    parameter int         CMD_TIMEOUT = 1024,
    parameter logic [7:0] VERSION     = 8'h01
) (
    input  logic             clk,
    input  logic             rst,
    output logic             rxfifo_rd_o,
    input  logic [7:0]       rxfifo_data_i,
    input  logic             rxfifo_valid_i,
    input  logic             rxfifo_empty_i,
    output logic [7:0]       txfifo_data_o,
    output logic             txfifo_wr_o,
    input  logic             txfifo_full_i,
    output logic [LED_W-1:0] led_o,
    output logic             busy_o,
    output logic             cmd_err_o
);
    typedef enum logic [1:0] {IDLE, STREAM, STATUS} state_t;
    state_t           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [7:0]       op_q, op_d;
    logic [23:0]      arg_q, arg_d;
    logic             exec_q, exec_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [7:0]       data_q, data_d;
    logic [7:0]       led_s_q, led_s_d;
    logic [7:0]       err_s_q, err_s_d;
    logic [7:0]       err_cnt_q, err_cnt_d;
    logic [LED_W-1:0] led_q, led_d;
    logic             err_q, err_d;
    logic             tmo_hit;
    logic             wr;

    assign wr            = (state_q != IDLE) && !txfifo_full_i && !rst;
    assign rxfifo_rd_o   = !rxfifo_empty_i && !rst;
    assign txfifo_wr_o   = wr;
    assign txfifo_data_o = data_q;
    assign led_o         = led_q;
    assign busy_o        = state_q != IDLE;
    assign cmd_err_o     = err_q;

`ifdef FT_CMD_TIMEOUT_EN
    localparam int TW = $clog2(CMD_TIMEOUT + 1);
    logic [TW-1:0] tmo_q;
    assign tmo_hit = (idx_q != 2'd0) && !rxfifo_valid_i && (tmo_q == TW'(CMD_TIMEOUT));
    // Idle counter: runs only while a command is partly assembled and restarts on every received byte
    always_ff @(posedge clk)
        if (rst || rxfifo_valid_i || idx_q == 2'd0 || tmo_hit) tmo_q <= '0;
        else tmo_q <= tmo_q + TW'(1);
`else
    assign tmo_hit = (CMD_TIMEOUT < 0);
`endif

    // Next state: byte assembly, TX write sequencing, then command execution which may override the TX path
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        op_d      = op_q;
        arg_d     = arg_q;
        exec_d    = 1'b0;
        rem_d     = rem_q;
        data_d    = data_q;
        led_d     = led_q;
        led_s_d   = led_s_q;
        err_s_d   = err_s_q;
        err_d     = tmo_hit;
        err_cnt_d = err_cnt_q;
        if (rxfifo_valid_i) begin
            idx_d  = idx_q + 2'd1;
            op_d   = idx_q == 2'd0 ? rxfifo_data_i : op_q;
            arg_d  = idx_q == 2'd0 ? arg_q : {rxfifo_data_i, arg_q[23:8]};
            exec_d = idx_q == 2'd3;
        end else if (tmo_hit) begin
            idx_d = 2'd0;
        end
        if (wr) begin
            rem_d   = rem_q - CNT_W'(1);
            data_d  = state_q == STREAM ? data_q + 8'd1 :
                      rem_q == CNT_W'(4) ? led_s_q :
                      rem_q == CNT_W'(3) ? err_s_q : VERSION;
            state_d = rem_q == CNT_W'(1) ? IDLE : state_q;
        end
        if (exec_q) begin
            if (op_q == 8'h01) begin
                led_d = arg_q[LED_W-1:0];
            end else if (op_q == 8'h02 && state_q == IDLE && arg_q != '0) begin
                state_d = STREAM;
                rem_d   = CNT_W'(arg_q);
                data_d  = 8'h00;
            end else if (op_q == 8'h03 && state_q == IDLE) begin
                state_d = STATUS;
                rem_d   = CNT_W'(4);
                data_d  = 8'h5A;
                led_s_d = 8'(led_q);
                err_s_d = err_cnt_q;
            end else if (op_q == 8'h04) begin
                state_d = state_q == STREAM ? IDLE : state_d;
            end else begin
                err_d = 1'b1;
            end
        end
        err_cnt_d = (err_d && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
    end

    // State register: everything clears on reset, dropping any partial command
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= 2'd0;
            op_q      <= 8'h00;
            arg_q     <= 24'h0;
            exec_q    <= 1'b0;
            rem_q     <= '0;
            data_q    <= 8'h00;
            led_s_q   <= 8'h00;
            err_s_q   <= 8'h00;
            err_cnt_q <= 8'h00;
            led_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            op_q      <= op_d;
            arg_q     <= arg_d;
            exec_q    <= exec_d;
            rem_q     <= rem_d;
            data_q    <= data_d;
            led_s_q   <= led_s_d;
            err_s_q   <= err_s_d;
            err_cnt_q <= err_cnt_d;
            led_q     <= led_d;
            err_q     <= err_d;
        end
    end
endmodule

// File: tb/tb_ft_cmd_ctrl.sv
// tb_ft_cmd_ctrl: directed and randomized checks of ft_cmd_ctrl against a command-level reference model
module tb_ft_cmd_ctrl;
    logic       clk = 1'b0, rst = 1'b1;
    logic       rxfifo_rd, rxfifo_valid = 1'b0, rxfifo_empty = 1'b1;
    logic       txfifo_wr, txfifo_full = 1'b0, busy, cmd_err;
    logic [7:0] rxfifo_data = 8'h00, txfifo_data, led;
    int         checks = 0, errors = 0;
    int         cyc = 0, last_valid_cyc = 0, last_wr_cyc = 0;
    int         pulses = 0, bad_full = 0, bad_busy = 0;
    int         full_mode = 0;
    bit         rx_gaps = 1'b0;
    logic [7:0] rxq[$], txlog[$], expq[$];
    int         txcyc[$];
    logic [7:0] m_led = 8'h00, m_err = 8'h00;
    int         m_pulses = 0;

    ft_cmd_ctrl #(.LED_W(8), .CMD_TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .rxfifo_rd_o(rxfifo_rd), .rxfifo_data_i(rxfifo_data), .rxfifo_valid_i(rxfifo_valid),
        .rxfifo_empty_i(rxfifo_empty), .txfifo_data_o(txfifo_data), .txfifo_wr_o(txfifo_wr),
        .txfifo_full_i(txfifo_full), .led_o(led), .busy_o(busy), .cmd_err_o(cmd_err)
    );

    always #5 clk = ~clk;

    // RX FIFO / TX FIFO environment and write monitor
    initial begin
        bit took;
        forever begin
            @(posedge clk);
            took = rxfifo_rd;
            @(negedge clk);
            cyc++;
            rxfifo_valid = took && rxq.size() > 0;
            if (rxfifo_valid) begin
                rxfifo_data = rxq.pop_front();
                last_valid_cyc = cyc;
            end
            rxfifo_empty = rxq.size() == 0 || (rx_gaps && $urandom_range(3) == 0);
            txfifo_full = full_mode == 3 || (full_mode == 1 && $urandom_range(2) == 0) ||
                          (full_mode == 2 && (cyc / 3) % 2 == 1);
            #1;
            if (txfifo_wr === 1'b1) begin
                txlog.push_back(txfifo_data);
                txcyc.push_back(cyc);
                last_wr_cyc = cyc;
                if (txfifo_full) bad_full++;
                if (busy !== 1'b1) bad_busy++;
            end
            if (cmd_err === 1'b1) pulses++;
        end
    end

    function automatic void m_error();
        m_pulses++;
        if (m_err != 8'hFF) m_err++;
    endfunction

    function automatic void m_exec(input logic [7:0] op, input logic [23:0] arg, input bit idle);
        if (op == 8'h01) m_led = arg[7:0];
        else if (op == 8'h02 && idle && arg != 24'h0)
            for (int i = 0; i < int'(arg); i++) expq.push_back(i[7:0]);
        else if (op == 8'h03 && idle) begin
            expq.push_back(8'h5A);
            expq.push_back(m_led);
            expq.push_back(m_err);
            expq.push_back(8'h01);
        end else if (op != 8'h04) m_error();
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    // mode 0: raw bytes only, 1: model sees TX idle, 2: model sees TX busy
    task automatic send(input logic [7:0] op, input logic [23:0] arg, input int mode);
        rxq.push_back(op);
        rxq.push_back(arg[7:0]);
        rxq.push_back(arg[15:8]);
        rxq.push_back(arg[23:16]);
        if (mode != 0) m_exec(op, arg, mode == 1);
    endtask

    task automatic wait_rx(input string tag);
        int n = 0;
        while (rxq.size() != 0 && n < 3000) begin
            tick(1);
            n++;
        end
        check({tag, "_rx"}, rxq.size(), 0);
    endtask

    task automatic settle(input string tag);
        int n = 0;
        wait_rx(tag);
        tick(4);
        while (busy === 1'b1 && n < 5000) begin
            tick(1);
            n++;
        end
        check({tag, "_idle"}, busy, 0);
        tick(2);
    endtask

    task automatic cmp_log(input string tag);
        check({tag, "_len"}, txlog.size(), expq.size());
        for (int i = 0; i < expq.size() && i < txlog.size(); i++) check(tag, txlog[i], expq[i]);
        txlog.delete();
        expq.delete();
        txcyc.delete();
    endtask

    task automatic check_seq(input string tag);
        check({tag, "_some"}, 32'(txlog.size() > 0), 1);
        for (int i = 0; i < txlog.size(); i++) check(tag, txlog[i], i[7:0]);
        txlog.delete();
        txcyc.delete();
    endtask

    initial begin
        logic [7:0]  op;
        logic [23:0] arg;
        int          v;
        tick(3);
        check("rst_led", led, 0);
        check("rst_busy", busy, 0);
        check("rst_err", cmd_err, 0);
        check("rst_wr", txfifo_wr, 0);
        check("rst_data", txfifo_data, 0);
        rxq.push_back(8'h01);
        tick(2);
        check("rst_rd", rxfifo_rd, 0);
        check("rst_hold", rxq.size(), 1);
        rst = 1'b0;
        rxq.push_back(8'h2A);
        rxq.push_back(8'h00);
        rxq.push_back(8'h00);
        m_exec(8'h01, 24'h00002A, 1'b1);
        settle("led");
        check("led_val", led, 8'h2A);
        check("led_pulses", pulses, m_pulses);
        cmp_log("led_tx");

        send(8'h02, 24'h000005, 1);
        settle("s5");
        check("s5_consec", txcyc.size() == 5 ? txcyc[4] - txcyc[0] : -1, 4);
        cmp_log("s5");
        send(8'h02, 24'h000001, 1);
        settle("s1");
        cmp_log("s1");

        full_mode = 2;
        send(8'h02, 24'h000102, 1);
        settle("s258");
        cmp_log("s258");
        check("s258_full", bad_full, 0);
        full_mode = 0;

        send(8'h02, 24'h100000, 0);
        wait_rx("abort_start");
        tick(40);
        send(8'h04, 24'h000000, 0);
        wait_rx("abort");
        v = last_valid_cyc;
        tick(6);
        check("abort_busy", busy, 0);
        check("abort_stop", 32'(last_wr_cyc <= v + 1), 1);
        check("abort_run", 32'(last_wr_cyc >= v), 1);
        check_seq("abort_seq");
        send(8'h03, 24'h000000, 1);
        settle("stat1");
        cmp_log("stat1");

        send(8'h07, 24'h000000, 1);
        settle("bad7");
        send(8'h02, 24'h100000, 0);
        wait_rx("ss_start");
        tick(10);
        send(8'h02, 24'h000005, 2);
        wait_rx("ss");
        tick(6);
        check("ss_pulses", pulses, m_pulses);
        check("ss_two", m_pulses, 2);
        send(8'h04, 24'h000000, 0);
        settle("ss_abort");
        check_seq("ss_seq");
        send(8'h03, 24'h000000, 1);
        settle("stat2");
        cmp_log("stat2");

        full_mode = 3;
        send(8'h03, 24'h000000, 1);
        send(8'h04, 24'h000000, 1);
        wait_rx("hold");
        tick(20);
        check("hold_busy", busy, 1);
        check("hold_nowr", txlog.size(), 0);
        full_mode = 0;
        settle("hold");
        cmp_log("hold");
        check("hold_pulses", pulses, m_pulses);

        send(8'h02, 24'h000000, 1);
        settle("zero");
        send(8'h02, 24'h000800, 0);
        wait_rx("mid_start");
        tick(5);
        send(8'h02, 24'h000005, 2);
        send(8'h03, 24'h000000, 2);
        op = 8'($urandom);
        send(8'h01, {16'h0, op}, 2);
        wait_rx("mid");
        tick(5);
        check("mid_busy", busy, 1);
        check("mid_led", led, m_led);
        send(8'h04, 24'h000000, 0);
        settle("mid_abort");
        check_seq("mid_seq");
        check("mid_pulses", pulses, m_pulses);

`ifdef FT_CMD_TIMEOUT_EN
        rxq.push_back(8'h01);
        tick(25);
        m_error();
        check("tmo_pulse", pulses, m_pulses);
        send(8'h01, 24'h000033, 1);
        settle("tmo");
`else
        rxq.push_back(8'h01);
        tick(40);
        check("wait_pulse", pulses, m_pulses);
        rxq.push_back(8'h33);
        rxq.push_back(8'h00);
        rxq.push_back(8'h00);
        m_exec(8'h01, 24'h000033, 1'b1);
        settle("wait");
`endif
        check("part_led", led, 8'h33);
        cmp_log("part_tx");

        rx_gaps = 1'b1;
        full_mode = 1;
        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(4))
                0: begin op = 8'h01; arg = 24'($urandom); end
                1: begin op = 8'h02; arg = 24'($urandom_range(1, 20)); end
                2: begin op = 8'h03; arg = 24'($urandom); end
                3: begin op = 8'h04; arg = 24'($urandom); end
                default: begin op = $urandom_range(1) == 0 ? 8'h00 : 8'($urandom_range(5, 255)); arg = 24'($urandom); end
            endcase
            send(op, arg, 1);
            settle("rnd");
        end
        cmp_log("rnd");
        check("rnd_led", led, m_led);
        check("rnd_pulses", pulses, m_pulses);
        check("rnd_full", bad_full, 0);
        rx_gaps = 1'b0;
        full_mode = 0;

        repeat (260) send(8'($urandom_range(5, 255)), 24'($urandom), 1);
        settle("sat");
        send(8'h03, 24'h000000, 1);
        settle("sat_stat");
        check("sat_model", m_err, 8'hFF);
        cmp_log("sat_stat");
        check("sat_pulses", pulses, m_pulses);
        check("busy_wr", bad_busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
